// File: rtl/picorv32_qchannel_pmu_if.sv
// Handshake bundle between the Q-channel PMU, the system power requester and the
// retention-enabled picorv32 core.
interface picorv32_qchannel_pmu_if #(
    parameter int DENY_W = 8
);
    logic              sleep_req;
    logic              wake_req;
    logic              qacceptn;
    logic              qdeny;
    logic              qreqn;
    logic              pr_save;
    logic              pr_restore;
    logic              iso_en;
    logic              pwr_en;
    logic [DENY_W-1:0] deny_cnt;
    logic [3:0]        fsm_state;

    modport master (
        input  sleep_req, wake_req, qacceptn, qdeny,
        output qreqn, pr_save, pr_restore, iso_en, pwr_en, deny_cnt, fsm_state
    );

    modport slave (
        output sleep_req, wake_req, qacceptn, qdeny,
        input  qreqn, pr_save, pr_restore, iso_en, pwr_en, deny_cnt, fsm_state
    );
endinterface

// File: rtl/picorv32_qchannel_pmu.sv
// Q-channel power sequencer for a retention-capable picorv32: request, save, isolate,
// power-cycle, restore and exit. Every output comes straight from a flop.
module picorv32_qchannel_pmu #(
    parameter int ISO_DLY   = 2,
    parameter int OFF_MIN   = 4,
    parameter int PWRUP_DLY = 3,
    parameter int DENY_W    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    picorv32_qchannel_pmu_if.master bus
);
    typedef enum logic [3:0] {
        ST_RUN     = 4'd0,
        ST_REQ     = 4'd1,
        ST_DENY    = 4'd2,
        ST_SAVE    = 4'd3,
        ST_ISO     = 4'd4,
        ST_OFF     = 4'd5,
        ST_ON      = 4'd6,
        ST_RESTORE = 4'd7,
        ST_EXIT    = 4'd8
    } state_t;

    localparam logic [7:0] ISO_LOAD   = 8'(ISO_DLY - 1);
    localparam logic [7:0] OFF_LOAD   = 8'(OFF_MIN - 1);
    localparam logic [7:0] PWRUP_LOAD = 8'(PWRUP_DLY - 1);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              wake_q, wake_d;
    logic [DENY_W-1:0] deny_cnt_q, deny_cnt_d;
    logic              qreqn_q, qreqn_d;
    logic              pr_save_q, pr_save_d;
    logic              pr_restore_q, pr_restore_d;
    logic              iso_en_q, iso_en_d;
    logic              pwr_en_q, pwr_en_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wake_d     = wake_q;
        deny_cnt_d = deny_cnt_q;

        case (state_q)
            ST_RUN: begin
                // qreqn may only fall while the core sits in Q_RUN
                if (bus.sleep_req && bus.qacceptn && !bus.qdeny)
                    state_d = ST_REQ;
            end
            ST_REQ: begin
                if (!bus.qacceptn) begin
                    state_d = ST_SAVE;
                end else if (bus.qdeny) begin
                    state_d = ST_DENY;
                    if (deny_cnt_q != '1)
                        deny_cnt_d = deny_cnt_q + DENY_W'(1);
                end
            end
            ST_DENY: begin
                if (bus.qacceptn && !bus.qdeny)
                    state_d = ST_RUN;
            end
            ST_SAVE: begin
                state_d = ST_ISO;
                cnt_d   = ISO_LOAD;
            end
            ST_ISO: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_OFF;
                    cnt_d   = OFF_LOAD;
                    wake_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_OFF: begin
                // An early wake is remembered and honoured once the minimum off time ends
                wake_d = wake_q | bus.wake_req;
                if (cnt_q == 8'd0) begin
                    if (wake_q || bus.wake_req) begin
                        state_d = ST_ON;
                        cnt_d   = PWRUP_LOAD;
                        wake_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_ON: begin
                if (cnt_q == 8'd0)
                    state_d = ST_RESTORE;
                else
                    cnt_d = cnt_q - 8'd1;
            end
            ST_RESTORE: begin
                state_d = ST_EXIT;
            end
            ST_EXIT: begin
                if (bus.qacceptn)
                    state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it
        qreqn_d      = (state_d == ST_RUN) || (state_d == ST_DENY) || (state_d == ST_EXIT);
        pr_save_d    = (state_d == ST_SAVE);
        pr_restore_d = (state_d == ST_RESTORE);
        iso_en_d     = (state_d == ST_ISO) || (state_d == ST_OFF) || (state_d == ST_ON);
        pwr_en_d     = (state_d != ST_OFF);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            cnt_q        <= 8'd0;
            wake_q       <= 1'b0;
            deny_cnt_q   <= '0;
            qreqn_q      <= 1'b1;
            pr_save_q    <= 1'b0;
            pr_restore_q <= 1'b0;
            iso_en_q     <= 1'b0;
            pwr_en_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wake_q       <= wake_d;
            deny_cnt_q   <= deny_cnt_d;
            qreqn_q      <= qreqn_d;
            pr_save_q    <= pr_save_d;
            pr_restore_q <= pr_restore_d;
            iso_en_q     <= iso_en_d;
            pwr_en_q     <= pwr_en_d;
        end
    end

    assign bus.qreqn      = qreqn_q;
    assign bus.pr_save    = pr_save_q;
    assign bus.pr_restore = pr_restore_q;
    assign bus.iso_en     = iso_en_q;
    assign bus.pwr_en     = pwr_en_q;
    assign bus.deny_cnt   = deny_cnt_q;
    assign bus.fsm_state  = state_q;
endmodule
